// File: rtl/life_gen_engine.sv
// rtl/life_gen_engine.sv - Game-of-Life engine: one-cell-per-clock scan into a shadow board, atomic commit.
// Optional toroidal neighbourhood when LIFE_GEN_WRAP_EN is defined.
module life_gen_engine #(
    parameter int W_LOG2         = 3,
    parameter int H_LOG2         = 3,
    parameter int FRAMES_PER_GEN = 60,
    parameter logic [(1 << (W_LOG2 + H_LOG2))-1:0] SEED = 64'h0A30_1548_1148_1148
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_tick,
    input  logic                     run,
    input  logic                     reload,
    input  logic [W_LOG2+H_LOG2-1:0] rd_addr,
    output logic                     rd_cell,
    output logic                     busy,
    output logic                     gen_done,
    output logic [7:0]               gen_count
);
    localparam int AW   = W_LOG2 + H_LOG2;
    localparam int SIZE = 1 << AW;
    localparam int FCW  = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   cur_q, cur_d;
    logic [SIZE-1:0]   nxt_q, nxt_d;
    logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [7:0]        gen_count_q, gen_count_d;

    logic [H_LOG2-1:0] row, nr;
    logic [W_LOG2-1:0] col, nc;
    logic [3:0]        n_cnt;
    logic              in_board;
    logic              new_cell;

    // Neighbour offsets use truncating arithmetic so wrap-around is free.
    always_comb begin
        row      = idx_q[AW-1:W_LOG2];
        col      = idx_q[W_LOG2-1:0];
        n_cnt    = 4'd0;
        nr       = '0;
        nc       = '0;
        in_board = 1'b0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (!(dr == 1 && dc == 1)) begin
                    nr = row + H_LOG2'(dr) - H_LOG2'(1);
                    nc = col + W_LOG2'(dc) - W_LOG2'(1);
`ifdef LIFE_GEN_WRAP_EN
                    in_board = 1'b1;
`else
                    in_board = !((dr == 0 && row == '0) || (dr == 2 && &row) ||
                                 (dc == 0 && col == '0) || (dc == 2 && &col));
`endif
                    if (in_board && cur_q[{nr, nc}]) begin
                        n_cnt = n_cnt + 4'd1;
                    end
                end
            end
        end
        new_cell = (n_cnt == 4'd3) || (cur_q[idx_q] && n_cnt == 4'd2);
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        frame_cnt_d = frame_cnt_q;
        idx_d       = idx_q;
        gen_count_d = gen_count_q;
        case (state_q)
            IDLE: begin
                if (frame_tick && run) begin
                    if (frame_cnt_q == FC_LAST) begin
                        frame_cnt_d = '0;
                        idx_d       = '0;
                        state_d     = SCAN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FCW'(1);
                    end
                end
            end
            SCAN: begin
                nxt_d[idx_q] = new_cell;
                idx_d        = idx_q + AW'(1);
                if (&idx_q) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                cur_d       = nxt_q;
                gen_count_d = gen_count_q + 8'd1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reload overrides everything, including a coincident frame tick.
        if (reload) begin
            cur_d       = SEED;
            state_d     = IDLE;
            frame_cnt_d = '0;
            idx_d       = '0;
            gen_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= SEED;
            nxt_q       <= '0;
            frame_cnt_q <= '0;
            idx_q       <= '0;
            gen_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            frame_cnt_q <= frame_cnt_d;
            idx_q       <= idx_d;
            gen_count_q <= gen_count_d;
        end
    end

    assign rd_cell   = cur_q[rd_addr];
    assign busy      = (state_q != IDLE);
    assign gen_done  = (state_q == COMMIT);
    assign gen_count = gen_count_q;
endmodule

// File: tb/tb_life_gen_engine.sv
// tb/tb_life_gen_engine.sv - directed self-checking bench for life_gen_engine.
module tb_life_gen_engine;
    localparam logic [63:0] SEED_DEF  = 64'h0A30_1548_1148_1148;
    localparam logic [63:0] SEED_BLK  = 64'h0000_0000_0000_0E00;
    localparam logic [63:0] SEED_EDGE = 64'h0000_0000_0000_0083;
    localparam logic [63:0] BLK_VERT  = 64'h0000_0000_0004_0404;
`ifdef LIFE_GEN_WRAP_EN
    localparam logic [63:0] EDGE_GEN1 = 64'h0100_0000_0000_0101;
`else
    localparam logic [63:0] EDGE_GEN1 = 64'h0000_0000_0000_0000;
`endif

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, run, reload;
    logic [5:0] rd_addr;
    logic       rd_cell_d, busy_d, gd_d;
    logic       rd_cell_b, busy_b, gd_b;
    logic       rd_cell_e, busy_e, gd_e;
    logic [7:0] gc_d, gc_b, gc_e;

    int checks   = 0;
    int failures = 0;

    logic [63:0] b_dut, b_blk, b_edge;
    int          nb, ng, gd_seen;
    logic        busy_seen;

    always #5 clk = ~clk;

    life_gen_engine u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .reload(reload),
        .rd_addr(rd_addr), .rd_cell(rd_cell_d), .busy(busy_d), .gen_done(gd_d), .gen_count(gc_d)
    );

    life_gen_engine #(.SEED(SEED_BLK)) u_blk (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .reload(reload),
        .rd_addr(rd_addr), .rd_cell(rd_cell_b), .busy(busy_b), .gen_done(gd_b), .gen_count(gc_b)
    );

    life_gen_engine #(.SEED(SEED_EDGE)) u_edge (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .run(run), .reload(reload),
        .rd_addr(rd_addr), .rd_cell(rd_cell_e), .busy(busy_e), .gen_done(gd_e), .gen_count(gc_e)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cell(input string tag, input logic [5:0] a, input logic exp);
        rd_addr = a;
        #1;
        check(tag, 64'(rd_cell_d), 64'(exp));
    endtask

    task automatic read_board();
        for (int i = 0; i < 64; i++) begin
            rd_addr = 6'(i);
            #1;
            b_dut[i]  = rd_cell_d;
            b_blk[i]  = rd_cell_b;
            b_edge[i] = rd_cell_e;
        end
    endtask

    // Tick is consumed by the posedge between the two negedges; caller samples right after.
    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic trigger(input string tag);
        repeat (59) pulse_tick();
        check({tag, "_busy_before_60"}, 64'(busy_d), 64'd0);
        pulse_tick();
        check({tag, "_busy_after_60"}, 64'(busy_d), 64'd1);
    endtask

    // Counts busy cycles and gen_done pulses until busy falls, bounded at 200 cycles.
    task automatic wait_gen(input bit inject);
        nb = 0;
        ng = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busy_d) break;
            nb++;
            ng += int'(gd_d);
            frame_tick = inject && (nb % 10 == 0) && (nb <= 60);
            @(negedge clk);
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; run = 1'b0; reload = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_cell("rst_cell3", 6'd3, 1'b1);
        check_cell("rst_cell6", 6'd6, 1'b1);
        check_cell("rst_cell59", 6'd59, 1'b1);
        check_cell("rst_cell0", 6'd0, 1'b0);
        check_cell("rst_cell63", 6'd63, 1'b0);
        check("rst_busy", 64'(busy_d), 64'd0);
        check("rst_gen_done", 64'(gd_d), 64'd0);
        check("rst_gen_count", 64'(gc_d), 64'd0);
        read_board();
        check("rst_board", b_dut, SEED_DEF);

        run = 1'b1;
        trigger("gen1");
        wait_gen(1'b0);
        check("gen1_busy_len", 64'(nb), 64'd65);
        check("gen1_done_pulses", 64'(ng), 64'd1);
        read_board();
        check("gen1_blinker", b_blk, BLK_VERT);
        check("gen1_edge_board", b_edge, EDGE_GEN1);
        check("gen1_count", 64'(gc_b), 64'd1);

        trigger("gen2");
        wait_gen(1'b0);
        check("gen2_busy_len", 64'(nb), 64'd65);
        read_board();
        check("gen2_blinker", b_blk, SEED_BLK);
        check("gen2_count", 64'(gc_b), 64'd2);

        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        check("reload_count", 64'(gc_d), 64'd0);
        run = 1'b0;
        busy_seen = 1'b0;
        repeat (200) begin
            pulse_tick();
            busy_seen = busy_seen | busy_d;
        end
        check("norun_busy_seen", 64'(busy_seen), 64'd0);
        check("norun_count", 64'(gc_d), 64'd0);
        read_board();
        check("norun_board", b_dut, SEED_DEF);

        run = 1'b1;
        trigger("run_resume");
        wait_gen(1'b1);
        check("inject_busy_len", 64'(nb), 64'd65);
        check("inject_done_pulses", 64'(ng), 64'd1);
        check("inject_count", 64'(gc_d), 64'd1);
        trigger("after_inject");

        repeat (29) @(negedge clk);
        check("scan30_busy", 64'(busy_d), 64'd1);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("abort_busy", 64'(busy_d), 64'd0);
        check("abort_gen_done", 64'(gd_d), 64'd0);
        check("abort_count", 64'(gc_d), 64'd0);
        read_board();
        check("abort_board", b_dut, SEED_DEF);
        gd_seen = 0;
        busy_seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            gd_seen += int'(gd_d);
            busy_seen = busy_seen | busy_d;
        end
        check("abort_no_done", 64'(gd_seen), 64'd0);
        check("abort_no_busy", 64'(busy_seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
